// File: rtl/sram_axi_bridge_pkg.sv
// sram_axi_bridge_pkg: shared FSM encodings, AXI IDs and fixed AXI field values
// Used by sram_axi_bridge (read FSM, arbitration) and axi_wr_channel (write FSM).
package sram_axi_bridge_pkg;
  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} wr_state_t;
  localparam logic [3:0] ID_INST   = 4'd0;
  localparam logic [3:0] ID_DATA   = 4'd1;
  localparam logic [7:0] AXI_LEN   = 8'd0;
  localparam logic [1:0] AXI_BURST = 2'b01;
  localparam logic [1:0] AXI_LOCK  = 2'b00;
  localparam logic [3:0] AXI_CACHE = 4'd0;
  localparam logic [2:0] AXI_PROT  = 3'd0;
endpackage

// File: rtl/sram_axi_bridge_axi_wr_channel.sv
// axi_wr_channel: single-beat AXI write FSM with latched payload and independent AW/W handshakes
// Ports: clk, reset (sync, active-high); i_start launches a write with i_addr/i_size/i_wdata/i_wstrb
// (only honoured in W_IDLE, reported by o_idle); AW/W/B channel valids, readies and payload.
module axi_wr_channel
  import sram_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  input  logic        i_awready,
  input  logic        i_wready,
  input  logic        i_bvalid,
  output logic        o_idle,
  output logic [31:0] o_awaddr,
  output logic [2:0]  o_awsize,
  output logic        o_awvalid,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_wvalid,
  output logic        o_bready
);
  wr_state_t   r_state, w_next;
  logic        r_aw_done, r_w_done;
  logic [31:0] r_addr, r_wdata;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic        w_aw_fire, w_w_fire;
  assign w_aw_fire = o_awvalid & i_awready;
  assign w_w_fire  = o_wvalid & i_wready;
  assign o_awaddr  = r_addr;
  assign o_awsize  = {1'b0, r_size};
  assign o_wdata   = r_wdata;
  assign o_wstrb   = r_wstrb;
  always_ff @(posedge clk)
    r_state <= reset ? W_IDLE : w_next;
  // AW and W may complete in either order or together; leave only once both are done.
  always_comb begin
    w_next = r_state;
    case (r_state)
      W_IDLE:  w_next = i_start ? W_REQ : W_IDLE;
      W_REQ:   w_next = ((r_aw_done | w_aw_fire) & (r_w_done | w_w_fire)) ? W_B : W_REQ;
      W_B:     w_next = i_bvalid ? W_IDLE : W_B;
      default: w_next = W_IDLE;
    endcase
  end
  always_comb begin
    o_idle    = r_state == W_IDLE;
    o_awvalid = (r_state == W_REQ) & !r_aw_done;
    o_wvalid  = (r_state == W_REQ) & !r_w_done;
    o_bready  = r_state == W_B;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_addr    <= '0;
      r_size    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_aw_done <= (w_next == W_REQ) & (r_aw_done | w_aw_fire);
      r_w_done  <= (w_next == W_REQ) & (r_w_done | w_w_fire);
      if (i_start && r_state == W_IDLE) begin
        r_addr  <= i_addr;
        r_size  <= i_size;
        r_wdata <= i_wdata;
        r_wstrb <= i_wstrb;
      end
    end
  end
endmodule

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: merges inst/data SRAM-like ports into one single-beat AXI3 master
// Ports: clk, reset (sync, active-high); inst_sram_* and data_sram_* request/handshake ports;
// AXI3 AR/R/AW/W/B channels. Define BRIDGE_DATA_PRIO_EN for fixed data-over-inst read
// priority; otherwise reads are arbitrated round-robin.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  rd_state_t   r_rstate, w_rnext;
  logic        r_data_busy;
  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;
  logic [3:0]  r_arid;
  logic        w_inst_elig, w_data_elig, w_grant_inst, w_grant_data;
  logic        w_wr_idle, w_wr_start, w_unused;
  assign w_unused = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bid, bresp};
  assign w_inst_elig = inst_sram_req & (r_rstate == R_IDLE);
  assign w_data_elig = data_sram_req & !data_sram_wr & (r_rstate == R_IDLE) & !r_data_busy;
`ifdef BRIDGE_DATA_PRIO_EN
  assign w_grant_data = w_data_elig;
`else
  // r_rr_last: 1 = data won the last read grant, so inst wins the next contention.
  logic r_rr_last;
  assign w_grant_data = w_data_elig & (!w_inst_elig | !r_rr_last);
  always_ff @(posedge clk)
    if (reset) r_rr_last <= 1'b0;
    else if (w_grant_inst | w_grant_data) r_rr_last <= w_grant_data;
`endif
  assign w_grant_inst = w_inst_elig & !w_grant_data;
  // Data writes bypass read arbitration; data_busy keeps the data port to one outstanding.
  assign w_wr_start        = data_sram_req & data_sram_wr & w_wr_idle & !r_data_busy;
  assign inst_sram_addr_ok = w_grant_inst;
  assign data_sram_addr_ok = w_grant_data | w_wr_start;
  assign inst_sram_data_ok = rvalid & rready & (rid == ID_INST);
  assign data_sram_data_ok = (rvalid & rready & (rid == ID_DATA)) | (bvalid & bready);
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;
  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arsize  = r_arsize;
  assign arlen   = AXI_LEN;
  assign arburst = AXI_BURST;
  assign arlock  = AXI_LOCK;
  assign arcache = AXI_CACHE;
  assign arprot  = AXI_PROT;
  assign awid    = ID_DATA;
  assign awlen   = AXI_LEN;
  assign awburst = AXI_BURST;
  assign awlock  = AXI_LOCK;
  assign awcache = AXI_CACHE;
  assign awprot  = AXI_PROT;
  assign wid     = ID_DATA;
  assign wlast   = 1'b1;
  always_ff @(posedge clk)
    r_rstate <= reset ? R_IDLE : w_rnext;
  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  w_rnext = (w_grant_inst | w_grant_data) ? R_AR : R_IDLE;
      R_AR:    w_rnext = arready ? R_R : R_AR;
      R_R:     w_rnext = rvalid ? R_IDLE : R_R;
      default: w_rnext = R_IDLE;
    endcase
  end
  always_comb begin
    arvalid = r_rstate == R_AR;
    rready  = r_rstate == R_R;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_araddr    <= '0;
      r_arsize    <= '0;
      r_arid      <= '0;
      r_data_busy <= 1'b0;
    end else begin
      r_data_busy <= data_sram_addr_ok ? 1'b1 : data_sram_data_ok ? 1'b0 : r_data_busy;
      if (w_grant_inst | w_grant_data) begin
        r_araddr <= w_grant_data ? data_sram_addr : inst_sram_addr;
        r_arsize <= {1'b0, w_grant_data ? data_sram_size : inst_sram_size};
        r_arid   <= w_grant_data ? ID_DATA : ID_INST;
      end
    end
  end
  axi_wr_channel u_wr (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_wr_start),
    .i_addr    (data_sram_addr),
    .i_size    (data_sram_size),
    .i_wdata   (data_sram_wdata),
    .i_wstrb   (data_sram_wstrb),
    .i_awready (awready),
    .i_wready  (wready),
    .i_bvalid  (bvalid),
    .o_idle    (w_wr_idle),
    .o_awaddr  (awaddr),
    .o_awsize  (awsize),
    .o_awvalid (awvalid),
    .o_wdata   (wdata),
    .o_wstrb   (wstrb),
    .o_wvalid  (wvalid),
    .o_bready  (bready)
  );
endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge: scoreboard bench for sram_axi_bridge with a small AXI slave model
module tb_sram_axi_bridge;
  logic        clk, reset;
  logic        inst_sram_req, inst_sram_wr, inst_sram_addr_ok, inst_sram_data_ok;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  sram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [2:0] size; } ar_t;
  typedef struct packed { logic [31:0] addr; logic [2:0] size; } aw_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; } w_t;
  typedef struct packed { logic wr; logic [31:0] data; } dq_t;

  ar_t         exp_ar[$];
  aw_t         exp_aw[$];
  w_t          exp_w[$];
  logic [31:0] exp_inst[$];
  dq_t         exp_dq[$];
  logic [31:0] mem [logic [31:0]];
  int          total = 0, bad = 0;
  int          rd_dly = 1, aw_dly = 0, w_dly = 0;
  logic        b_hold = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, req);
    end
  endtask

  task automatic unexp(input string nm);
    total++;
    bad++;
    $display("FAIL %s: unexpected response, none required", nm);
  endtask

  // AXI read slave: returns mem[araddr] rd_dly cycles after the AR handshake.
  logic        s_ar_hs, s_r_hs, s_r_pend;
  logic [3:0]  s_cap_id, s_r_id;
  logic [31:0] s_cap_addr, s_r_addr;
  int          s_r_cnt;
  initial begin
    rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; s_r_pend = 0; s_r_cnt = 0;
    s_r_id = 0; s_r_addr = 0;
    forever begin
      @(negedge clk);
      s_ar_hs = arvalid & arready;
      s_r_hs = rvalid & rready;
      s_cap_id = arid;
      s_cap_addr = araddr;
      @(posedge clk); #1;
      if (reset) begin
        rvalid = 0; s_r_pend = 0;
      end else begin
        if (s_r_hs) rvalid = 0;
        if (s_ar_hs) begin s_r_pend = 1; s_r_cnt = 0; s_r_id = s_cap_id; s_r_addr = s_cap_addr; end
        if (s_r_pend) begin
          if (s_r_cnt >= rd_dly) begin
            rvalid = 1; rid = s_r_id; rdata = mem.exists(s_r_addr) ? mem[s_r_addr] : 32'h0; s_r_pend = 0;
          end else s_r_cnt++;
        end
      end
    end
  end

  // AXI write slave: awready/wready after aw_dly/w_dly cycles of valid; bvalid once both done and !b_hold.
  logic s_aw_hs, s_w_hs, s_b_hs, s_aw_got, s_w_got;
  int   s_aw_cnt, s_w_cnt;
  initial begin
    awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
    s_aw_got = 0; s_w_got = 0; s_aw_cnt = 0; s_w_cnt = 0;
    forever begin
      @(negedge clk);
      s_aw_hs = awvalid & awready;
      s_w_hs = wvalid & wready;
      s_b_hs = bvalid & bready;
      @(posedge clk); #1;
      if (reset) begin
        awready = 0; wready = 0; bvalid = 0; s_aw_got = 0; s_w_got = 0; s_aw_cnt = 0; s_w_cnt = 0;
      end else begin
        if (s_aw_hs) begin awready = 0; s_aw_got = 1; s_aw_cnt = 0; end
        else if (awvalid) begin awready = s_aw_cnt >= aw_dly; s_aw_cnt++; end
        if (s_w_hs) begin wready = 0; s_w_got = 1; s_w_cnt = 0; end
        else if (wvalid) begin wready = s_w_cnt >= w_dly; s_w_cnt++; end
        if (s_b_hs) begin bvalid = 0; s_aw_got = 0; s_w_got = 0; end
        else if (s_aw_got && s_w_got && !b_hold) begin bvalid = 1; bid = 4'd1; end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a handshake or data_ok.
  always @(negedge clk) begin
    ar_t e_ar; aw_t e_aw; w_t e_w; dq_t e_dq; logic [31:0] e_i;
    if (!reset) begin
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) unexp("ar");
        else begin
          e_ar = exp_ar.pop_front();
          chk("arid", {28'd0, arid}, {28'd0, e_ar.id});
          chk("araddr", araddr, e_ar.addr);
          chk("arsize", {29'd0, arsize}, {29'd0, e_ar.size});
          chk("ar_fixed", {13'd0, arlen, arburst, arlock, arcache, arprot}, {13'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
        end
      end
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) unexp("aw");
        else begin
          e_aw = exp_aw.pop_front();
          chk("awaddr", awaddr, e_aw.addr);
          chk("awsize", {29'd0, awsize}, {29'd0, e_aw.size});
          chk("aw_fixed", {9'd0, awid, awlen, awburst, awlock, awcache, awprot}, {9'd0, 4'd1, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
        end
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) unexp("w");
        else begin
          e_w = exp_w.pop_front();
          chk("wdata", wdata, e_w.data);
          chk("wstrb", {28'd0, wstrb}, {28'd0, e_w.strb});
          chk("w_fixed", {27'd0, wid, wlast}, {27'd0, 4'd1, 1'b1});
        end
      end
      if (inst_sram_data_ok) begin
        if (exp_inst.size() == 0) unexp("inst_data_ok");
        else begin
          e_i = exp_inst.pop_front();
          chk("inst_rdata", inst_sram_rdata, e_i);
        end
      end
      if (data_sram_data_ok) begin
        if (exp_dq.size() == 0) unexp("data_data_ok");
        else begin
          e_dq = exp_dq.pop_front();
          chk("data_ok_is_write", {31'd0, bvalid & bready}, {31'd0, e_dq.wr});
          if (!e_dq.wr) chk("data_rdata", data_sram_rdata, e_dq.data);
        end
      end
    end
  end

  task automatic exp_rd(input logic [3:0] id, input logic [31:0] a, input logic [31:0] d);
    exp_ar.push_back('{id: id, addr: a, size: 3'b010});
    mem[a] = d;
    if (id == 4'd0) exp_inst.push_back(d);
    else exp_dq.push_back('{wr: 1'b0, data: d});
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] sz);
    exp_aw.push_back('{addr: a, size: {1'b0, sz}});
    exp_w.push_back('{data: d, strb: s});
    exp_dq.push_back('{wr: 1'b1, data: 32'h0});
  endtask

  task automatic drv_inst(input logic [31:0] a);
    int n = 0;
    @(posedge clk); #1;
    inst_sram_req = 1; inst_sram_addr = a; inst_sram_size = 2'd2;
    @(negedge clk);
    while (!inst_sram_addr_ok && n < 200) begin @(negedge clk); n++; end
    chk("inst_addr_ok_wait", {31'd0, inst_sram_addr_ok}, 32'd1);
    @(posedge clk); #1;
    inst_sram_req = 0;
  endtask

  task automatic drv_data(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                          input logic [3:0] s, input logic [31:0] d);
    int n = 0;
    @(posedge clk); #1;
    data_sram_req = 1; data_sram_wr = wr; data_sram_addr = a; data_sram_size = sz;
    data_sram_wstrb = s; data_sram_wdata = d;
    @(negedge clk);
    while (!data_sram_addr_ok && n < 200) begin @(negedge clk); n++; end
    chk("data_addr_ok_wait", {31'd0, data_sram_addr_ok}, 32'd1);
    @(posedge clk); #1;
    data_sram_req = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_ar.size() != 0 || exp_aw.size() != 0 || exp_w.size() != 0 ||
            exp_inst.size() != 0 || exp_dq.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 500) begin
      bad++;
      $display("FAIL drain: %0d responses outstanding, required 0",
               exp_ar.size() + exp_aw.size() + exp_w.size() + exp_inst.size() + exp_dq.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    reset = 1; arready = 1;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 0; inst_sram_wstrb = 0;
    inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_wstrb = 0;
    data_sram_addr = 0; data_sram_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
    chk("rst_wvalid", {31'd0, wvalid}, 32'd0);
    chk("rst_bready", {31'd0, bready}, 32'd0);
    chk("rst_addr_ok", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'd0);
    chk("rst_data_ok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    @(posedge clk); #1;
    reset = 0;

    // Instruction fetch from the boot vector.
    rd_dly = 1;
    exp_rd(4'd0, 32'hBFC00000, 32'h3C080001);
    drv_inst(32'hBFC00000);
    wait_idle();

    // Halfword write with awready lagging wready by 3 cycles, then a word write with wready lagging.
    aw_dly = 3; w_dly = 0;
    exp_wr(32'h00000100, 32'hDEADBEEF, 4'b0011, 2'd1);
    drv_data(1'b1, 32'h00000100, 2'd1, 4'b0011, 32'hDEADBEEF);
    wait_idle();
    aw_dly = 0; w_dly = 2;
    exp_wr(32'h00000104, 32'h12345678, 4'b1111, 2'd2);
    drv_data(1'b1, 32'h00000104, 2'd2, 4'b1111, 32'h12345678);
    wait_idle();
    w_dly = 0;

    // Read contention: data port issues two reads back to back while inst holds one request.
`ifdef BRIDGE_DATA_PRIO_EN
    exp_rd(4'd1, 32'h00000200, 32'h11112222);
    exp_rd(4'd1, 32'h00000204, 32'h33334444);
    exp_rd(4'd0, 32'hBFC00004, 32'h8C020000);
`else
    exp_rd(4'd1, 32'h00000200, 32'h11112222);
    exp_rd(4'd0, 32'hBFC00004, 32'h8C020000);
    exp_rd(4'd1, 32'h00000204, 32'h33334444);
`endif
    fork
      drv_inst(32'hBFC00004);
      begin
        drv_data(1'b0, 32'h00000200, 2'd2, 4'h0, 32'h0);
        drv_data(1'b0, 32'h00000204, 2'd2, 4'h0, 32'h0);
      end
    join
    wait_idle();

    // Outstanding write with bvalid withheld: inst read still completes, data port stays blocked.
    b_hold = 1;
    exp_wr(32'h00000300, 32'hCAFEF00D, 4'b1111, 2'd2);
    drv_data(1'b1, 32'h00000300, 2'd2, 4'b1111, 32'hCAFEF00D);
    exp_rd(4'd0, 32'hBFC00008, 32'h24090002);
    drv_inst(32'hBFC00008);
    for (int n = 0; n < 100 && exp_inst.size() != 0; n++) @(negedge clk);
    chk("inst_during_wr_pending", exp_inst.size(), 32'd0);
    chk("wr_resp_pending", exp_dq.size(), 32'd1);
    exp_rd(4'd1, 32'h00000304, 32'h0BADF00D);
    fork
      drv_data(1'b0, 32'h00000304, 2'd2, 4'h0, 32'h0);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("busy_blocks_addr_ok", {31'd0, data_sram_addr_ok}, 32'd0);
        end
        @(posedge clk); #1;
        b_hold = 0;
      end
    join
    wait_idle();

    // Reset while arvalid is held in R_AR, then a clean fetch afterwards.
    arready = 0;
    @(posedge clk); #1;
    inst_sram_req = 1; inst_sram_addr = 32'hBFC00010; inst_sram_size = 2'd2;
    @(negedge clk);
    chk("pre_rst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    @(posedge clk); #1;
    inst_sram_req = 0;
    @(negedge clk);
    chk("pre_rst_arvalid", {31'd0, arvalid}, 32'd1);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("mid_rst_rready", {31'd0, rready}, 32'd0);
    @(posedge clk); #1;
    reset = 0; arready = 1;
    exp_rd(4'd0, 32'hBFC00014, 32'h3C1D8001);
    drv_inst(32'hBFC00014);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

Converts the CPU core's two SRAM-like master ports (instruction and data, req/addr_ok/data_ok handshake) into a single AXI3 master port toward the system interconnect. Sits directly downstream of the CPU core top. It arbitrates reads between the two ports and issues single-beat AXI read and write transactions. Responses return to the owning port with in-order data_ok.

## Interface
Parameters: none; widths fixed at 32-bit address/data, 4-bit AXI IDs.

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- inst_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  instruction port request; wr is always 0 and wstrb/wdata are ignored
- inst_sram_addr_ok/data_ok  out  1/1  instruction handshake
- inst_sram_rdata  out  32  instruction read data
- data_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  data port request
- data_sram_addr_ok/data_ok  out  1/1, data_sram_rdata out 32  data handshake and read data
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/8/3/2/2/4/3/1; arready in 1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1; rready out 1
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/8/3/2/2/4/3/1; awready in 1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1; wready in 1
- bid/bresp/bvalid  in  4/2/1; bready out 1

## Operation
- Constants: arlen/awlen=0, arburst/awburst=2'b01, lock/cache/prot=0, wlast=1, wid=awid=4'd1. ID assignment: inst read 4'd0, data read 4'd1. a*size={1'b0,size}.
- Read FSM, states R_IDLE → R_AR → R_R → R_IDLE:
  - R_IDLE→R_AR when a read is granted, latching addr, size and id.
  - R_AR drives arvalid=1 and moves to R_R on arready.
  - R_R drives rready=1. On rvalid it returns to R_IDLE.
- Write FSM, states W_IDLE → W_REQ → W_B → W_IDLE:
  - W_IDLE→W_REQ on an accepted data write, latching addr, size, wdata and wstrb.
  - W_REQ asserts awvalid and wvalid together. Each valid drops independently after its own handshake, tracked by aw_done/w_done. Move to W_B when both are done, including the same-cycle case.
  - W_B drives bready=1 and returns to W_IDLE on bvalid.
- data_busy: set on data addr_ok, cleared on data data_ok. The data port has at most one outstanding transaction, which guarantees in-order data_ok. The instruction port has at most one outstanding through the read FSM.
- addr_ok is combinational:
  - inst: inst_req & R_IDLE & inst granted.
  - data read: data_req & !wr & R_IDLE & !data_busy & granted.
  - data write: data_req & wr & W_IDLE & !data_busy.
- data_ok and rdata are combinational:
  - inst_data_ok = rvalid & rready & rid==0.
  - data_data_ok = (rvalid & rready & rid==1) | (bvalid & bready).
  - Both rdata outputs pass AXI rdata through directly.
- An instruction read may proceed concurrently with an outstanding data write.
- rresp and bresp are ignored.

## Timing
- Reset values: all valid/ready/addr_ok/data_ok outputs 0, both FSMs idle, data_busy=0, aw_done=w_done=0, rr_last=0, latched address/data 0.
- Read latency: addr_ok in cycle T; arvalid from T+1; data_ok in the same cycle as the rvalid handshake. Minimum 3 cycles with zero-wait AXI.
- Write latency: awvalid/wvalid from T+1; data_ok in the same cycle as the bvalid handshake.
- At most one addr_ok per port per cycle. A data read and an inst read are never both granted in one cycle.
- Reset mid-transaction returns the FSMs to idle immediately and drops all pending valids.
- AXI valids never drop before their handshake completes.

## Configuration
- BRIDGE_DATA_PRIO_EN defined: when both read requests are eligible in R_IDLE, the data read always wins.
- BRIDGE_DATA_PRIO_EN undefined: round-robin arbitration. Register rr_last records the last winner; on contention the other port wins.

## Structure
- Shared package holds the read state encodings R_IDLE/R_AR/R_R and the write state encodings W_IDLE/W_REQ/W_B. It also holds the ID constants ID_INST=4'd0 and ID_DATA=4'd1 and the AXI fixed-field constants.
- One sub-module, axi_wr_channel: the write FSM, aw_done/w_done tracking and the latched write payload. Arbitration and the read FSM stay in the top.

## Test plan
- Inst read of 0xBFC00000, arready=1, rvalid 2 cycles after ar:
  - expect araddr=0xBFC00000, arid=0, arsize=3'b010.
  - expect inst_data_ok with rdata 0x3C080001.
- Data write addr 0x00000100, wdata 0xDEADBEEF, wstrb 4'b0011, size 1:
  - expect awsize=1 and wstrb=0011.
  - with awready delayed 3 cycles past wready, expect one data_data_ok per bvalid.
- Inst and data read requests in the same cycle:
  - with the macro, expect data granted (arid=1) and inst addr_ok in the cycle after the data read returns.
  - without the macro, expect grants to alternate on repeated contention.
- Data write outstanding (bvalid withheld) while inst read requested:
  - expect the inst read to complete.
  - expect the next data req to get no addr_ok until bvalid.
- Reset asserted while in R_AR with arvalid=1 → arvalid=0 the next cycle, and a fresh request is accepted normally after reset deasserts.
